// File: rtl/pll_rst_seq_if.sv
// -----------------------------------------------------------------------------
// pll_rst_seq_if
//   Signal bundle between the clock-wizard reset sequencer and its users.
//
//   Signals:
//     locked        clock wizard lock flag (asynchronous to clk)
//     rst_out       active-high reset per clock domain, bit 0 released first
//     seq_done      high while every rst_out bit is released
//     lock_loss_cnt saturating count of lock-loss events
//     state_o       sequencer state for debug
//                   (WAIT_LOCK=0, STABLE=1, RELEASE=2, RUN=3)
//
//   Modports:
//     slave   the sequencer itself: consumes locked, produces everything else
//     master  the environment: drives locked, observes the reset outputs
//
//   Handshake semantics: there is no valid/ready pair here. locked is a level
//   that may change at any time; every output is a registered level that
//   changes only on a rising edge of clk.
// -----------------------------------------------------------------------------
interface pll_rst_seq_if #(
   parameter int NUM_STAGES = 4
);
   logic                  locked;
   logic [NUM_STAGES-1:0] rst_out;
   logic                  seq_done;
   logic [7:0]            lock_loss_cnt;
   logic [1:0]            state_o;

   modport slave (
      input  locked,
      output rst_out,
      output seq_done,
      output lock_loss_cnt,
      output state_o
   );

   modport master (
      output locked,
      input  rst_out,
      input  seq_done,
      input  lock_loss_cnt,
      input  state_o
   );
endinterface

// File: rtl/pll_rst_seq.sv
// -----------------------------------------------------------------------------
// pll_rst_seq
//   Reset sequencer sitting directly after the clock wizard. The wizard's
//   asynchronous locked flag is synchronized, required to stay high for
//   LOCK_STABLE_CYCLES consecutive cycles, and then the per-domain resets are
//   released one by one, STAGE_GAP cycles apart, lowest index first. Any loss
//   of lock re-asserts every reset, restarts the whole sequence and bumps a
//   saturating debug counter.
//
//   Ports:
//     clk   input   reference clock (same net that feeds the clock wizard)
//     rst   input   synchronous, active-high block reset
//     bus   slave modport of pll_rst_seq_if:
//             locked        in   wizard lock flag, asynchronous
//             rst_out       out  NUM_STAGES active-high domain resets
//             seq_done      out  all domain resets released
//             lock_loss_cnt out  saturating lock-loss event count
//             state_o       out  FSM state for debug
//
//   Parameters:
//     SYNC_STAGES         flops in the locked synchronizer (2..4)
//     LOCK_STABLE_CYCLES  consecutive high cycles before first release (>=1)
//     STAGE_GAP           cycles between successive releases (>=1)
//     NUM_STAGES          number of sequenced reset outputs (1..8)
//
//   Every output comes straight from a flop; locked has no combinational path
//   to any output.
// -----------------------------------------------------------------------------
module pll_rst_seq #(
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 64,
   parameter int STAGE_GAP          = 16,
   parameter int NUM_STAGES         = 4
) (
   input  logic         clk,
   input  logic         rst,
   pll_rst_seq_if.slave bus
);

   // One shared counter serves both the stability wait and the stage gap, so
   // it is sized for the larger of the two terminal values.
   localparam int CNT_MAX = (LOCK_STABLE_CYCLES > STAGE_GAP) ? LOCK_STABLE_CYCLES : STAGE_GAP;
   localparam int CW      = $clog2(CNT_MAX) + 1;
   localparam int SW      = $clog2(NUM_STAGES) + 1;

   localparam logic [CW-1:0] C_LOCK = CW'(LOCK_STABLE_CYCLES);
   localparam logic [CW-1:0] C_GAP  = CW'(STAGE_GAP);
   localparam logic [CW-1:0] C_ONE  = CW'(1);
   localparam logic [SW-1:0] C_LAST = SW'(NUM_STAGES - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] r_sync;
   state_t                 r_state;
   logic [CW-1:0]          r_cnt;
   logic [SW-1:0]          r_stage;
   logic [NUM_STAGES-1:0]  r_rst_out;
   logic                   r_seq_done;
   logic [7:0]             r_loss_cnt;

   // ---------------------------------------------------------------------------
   // Next-state wires
   // ---------------------------------------------------------------------------
   logic                   w_locked_s;
   state_t                 w_state_nxt;
   logic [CW-1:0]          w_cnt_nxt;
   logic [CW-1:0]          w_cnt_inc;
   logic [SW-1:0]          w_stage_nxt;
   logic [NUM_STAGES-1:0]  w_rst_out_nxt;
   logic                   w_seq_done_nxt;
   logic [7:0]             w_loss_cnt_nxt;
   logic                   w_first_rel;
   logic                   w_loss;

   // The last flop of the chain is the only one the FSM ever looks at; the
   // earlier flops exist purely to let metastability settle.
   assign w_locked_s = r_sync[SYNC_STAGES-1];
   assign w_cnt_inc  = r_cnt + C_ONE;

   // ---------------------------------------------------------------------------
   // Next-state / output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_stage_nxt    = r_stage;
      w_rst_out_nxt  = r_rst_out;
      w_seq_done_nxt = r_seq_done;
      w_loss_cnt_nxt = r_loss_cnt;
      w_first_rel    = 1'b0;
      w_loss         = 1'b0;

      case (r_state)
         WAIT_LOCK: begin
            w_rst_out_nxt  = '1;
            w_seq_done_nxt = 1'b0;
            w_cnt_nxt      = '0;
            w_stage_nxt    = '0;
            if (w_locked_s) begin
               // The edge that first sees locked_s high already counts as
               // one stable cycle, so a one-cycle wait releases right here.
               w_state_nxt = STABLE;
               w_cnt_nxt   = C_ONE;
               if (C_LOCK == C_ONE) begin
                  w_first_rel = 1'b1;
               end
            end
         end

         STABLE: begin
            if (!w_locked_s) begin
               w_loss = 1'b1;
            end else begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == C_LOCK) begin
                  w_first_rel = 1'b1;
               end
            end
         end

         RELEASE: begin
            if (!w_locked_s) begin
               w_loss = 1'b1;
            end else begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == C_GAP) begin
                  // Only the bit addressed by the stage index drops, which is
                  // what keeps releases strictly in index order.
                  for (int i = 0; i < NUM_STAGES; i++) begin
                     if (SW'(i) == r_stage) begin
                        w_rst_out_nxt[i] = 1'b0;
                     end
                  end
                  w_cnt_nxt   = '0;
                  w_stage_nxt = r_stage + SW'(1);
                  if (r_stage == C_LAST) begin
                     w_seq_done_nxt = 1'b1;
                     w_state_nxt    = RUN;
                  end
               end
            end
         end

         RUN: begin
            if (!w_locked_s) begin
               w_loss = 1'b1;
            end else begin
               w_rst_out_nxt  = '0;
               w_seq_done_nxt = 1'b1;
            end
         end

         default: begin
            w_state_nxt    = WAIT_LOCK;
            w_rst_out_nxt  = '1;
            w_seq_done_nxt = 1'b0;
            w_cnt_nxt      = '0;
            w_stage_nxt    = '0;
         end
      endcase

      // First release: stage 0 drops and the gap counter starts from zero.
      if (w_first_rel) begin
         w_rst_out_nxt[0] = 1'b0;
         w_stage_nxt      = SW'(1);
         w_cnt_nxt        = '0;
         if (NUM_STAGES == 1) begin
            w_seq_done_nxt = 1'b1;
            w_state_nxt    = RUN;
         end else begin
            w_state_nxt = RELEASE;
         end
      end

      // Lock loss is evaluated last so it beats any release that would have
      // happened on the same edge.
      if (w_loss) begin
         w_rst_out_nxt  = '1;
         w_seq_done_nxt = 1'b0;
         w_cnt_nxt      = '0;
         w_stage_nxt    = '0;
         w_state_nxt    = WAIT_LOCK;
         if (r_loss_cnt != 8'hFF) begin
            w_loss_cnt_nxt = r_loss_cnt + 8'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync     <= '0;
         r_state    <= WAIT_LOCK;
         r_cnt      <= '0;
         r_stage    <= '0;
         r_rst_out  <= '1;
         r_seq_done <= 1'b0;
         r_loss_cnt <= 8'd0;
      end else begin
         r_sync     <= {r_sync[SYNC_STAGES-2:0], bus.locked};
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_stage    <= w_stage_nxt;
         r_rst_out  <= w_rst_out_nxt;
         r_seq_done <= w_seq_done_nxt;
         r_loss_cnt <= w_loss_cnt_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.rst_out       = r_rst_out;
   assign bus.seq_done      = r_seq_done;
   assign bus.lock_loss_cnt = r_loss_cnt;
   assign bus.state_o       = r_state;

endmodule

// File: tb/tb_pll_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_pll_rst_seq
//   Self-checking bench for pll_rst_seq. The reference model tracks how many
//   consecutive edges the FSM has seen a high synchronized lock; every output
//   is a closed-form function of that run length and the loss count.
// -----------------------------------------------------------------------------
module tb_pll_rst_seq;

   localparam int SYNC_STAGES = 2;
   localparam int LSC         = 8;
   localparam int GAP         = 4;
   localparam int NST         = 4;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pll_rst_seq_if #(.NUM_STAGES(NST)) bus ();

   pll_rst_seq #(
      .SYNC_STAGES       (SYNC_STAGES),
      .LOCK_STABLE_CYCLES(LSC),
      .STAGE_GAP         (GAP),
      .NUM_STAGES        (NST)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [14:0] exp_q[$];   // {state, loss_cnt, seq_done, rst_out}

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   logic m_hist [SYNC_STAGES];  // locked as sampled on the last few edges
   int   m_run;                 // consecutive edges the FSM saw locked_s high
   int   m_loss;

   function automatic logic [14:0] model_expect();
      logic [NST-1:0] ro;
      logic           sd;
      logic [1:0]     st;
      for (int k = 0; k < NST; k++) begin
         ro[k] = !(m_run >= LSC + k * GAP);
      end
      sd = (m_run >= LSC + (NST - 1) * GAP);
      if (m_run == 0)       st = 2'd0;
      else if (m_run < LSC) st = 2'd1;
      else if (!sd)         st = 2'd2;
      else                  st = 2'd3;
      return {st, 8'(m_loss), sd, ro};
   endfunction

   task automatic model_edge(input logic r, input logic l);
      logic ls;
      if (r) begin
         for (int i = 0; i < SYNC_STAGES; i++) m_hist[i] = 1'b0;
         m_run  = 0;
         m_loss = 0;
      end else begin
         ls = m_hist[SYNC_STAGES-1];
         for (int i = SYNC_STAGES - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
         m_hist[0] = l;
         if (ls) begin
            if (m_run < 1000000) m_run++;
         end else begin
            if (m_run > 0 && m_loss < 255) m_loss++;
            m_run = 0;
         end
      end
      exp_q.push_back(model_expect());
   endtask

   // ---------------------------------------------------------------------------
   // Driver: one clock edge with the given inputs, then check at the negedge
   // ---------------------------------------------------------------------------
   task automatic tick(input logic r, input logic l);
      logic [14:0] e;
      rst        = r;
      bus.locked = l;
      @(posedge clk);
      model_edge(r, l);
      @(negedge clk);
      e = exp_q.pop_front();
      chk("rst_out",       32'(bus.rst_out),       32'(e[3:0]));
      chk("seq_done",      32'(bus.seq_done),      32'(e[4]));
      chk("lock_loss_cnt", 32'(bus.lock_loss_cnt), 32'(e[12:5]));
      chk("state_o",       32'(bus.state_o),       32'(e[14:13]));
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int lat;
      int hi;
      int lo;
      rst        = 1'b1;
      bus.locked = 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) m_hist[i] = 1'b0;
      m_run  = 0;
      m_loss = 0;

      // Power-up: reset values held throughout.
      for (int i = 0; i < 10; i++) begin
         tick(1'b1, 1'b0);
         chk("pwr_rst_out", 32'(bus.rst_out), 32'h0000000F);
         chk("pwr_state",   32'(bus.state_o), 32'd0);
      end

      // Clean lock: releases at E10, E14, E18, E22.
      for (int e = 1; e <= 24; e++) begin
         tick(1'b0, 1'b1);
         if (e == 9)  chk("s2_e9_rst_out",  32'(bus.rst_out), 32'hF);
         if (e == 10) chk("s2_e10_rst_out", 32'(bus.rst_out), 32'hE);
         if (e == 14) chk("s2_e14_rst_out", 32'(bus.rst_out), 32'hC);
         if (e == 18) chk("s2_e18_rst_out", 32'(bus.rst_out), 32'h8);
         if (e == 21) chk("s2_e21_done",    32'(bus.seq_done), 32'd0);
         if (e == 22) begin
            chk("s2_e22_rst_out", 32'(bus.rst_out),  32'h0);
            chk("s2_e22_done",    32'(bus.seq_done), 32'd1);
            chk("s2_e22_state",   32'(bus.state_o),  32'd3);
         end
      end

      // Glitch during STABLE, low sampled at E5.
      do_reset(3);
      for (int e = 1; e <= 20; e++) begin
         tick(1'b0, (e != 5));
         if (e == 7) begin
            chk("s3_e7_state", 32'(bus.state_o),       32'd0);
            chk("s3_e7_loss",  32'(bus.lock_loss_cnt), 32'd1);
         end
         if (e == 10) chk("s3_e10_rst_out", 32'(bus.rst_out), 32'hF);
         if (e == 14) chk("s3_e14_rst_out", 32'(bus.rst_out), 32'hF);
         if (e == 15) chk("s3_e15_rst_out", 32'(bus.rst_out), 32'hE);
      end

      // Loss during RELEASE: FSM sees locked_s=0 at E14.
      do_reset(3);
      for (int e = 1; e <= 36; e++) begin
         tick(1'b0, !(e == 12 || e == 13));
         if (e == 13) chk("s4_e13_rst_out", 32'(bus.rst_out), 32'hE);
         if (e == 14) begin
            chk("s4_e14_rst_out", 32'(bus.rst_out),       32'hF);
            chk("s4_e14_loss",    32'(bus.lock_loss_cnt), 32'd1);
         end
         if (e == 22) chk("s4_e22_rst_out", 32'(bus.rst_out), 32'hF);
         if (e == 23) chk("s4_e23_rst_out", 32'(bus.rst_out), 32'hE);
         if (e == 34) chk("s4_e34_done",    32'(bus.seq_done), 32'd0);
         if (e == 35) begin
            chk("s4_e35_rst_out", 32'(bus.rst_out),  32'h0);
            chk("s4_e35_done",    32'(bus.seq_done), 32'd1);
         end
      end

      // Repeated loss in RUN, counter saturates.
      do_reset(3);
      for (int it = 0; it < 300; it++) begin
         for (int c = 0; c < 24; c++) tick(1'b0, 1'b1);
         chk("s5_run_state", 32'(bus.state_o), 32'd3);
         lat = 0;
         while (bus.rst_out != 4'hF && lat < 10) begin
            tick(1'b0, 1'b0);
            lat++;
         end
         chk("s5_loss_latency", 32'(lat), 32'(SYNC_STAGES + 1));
         tick(1'b0, 1'b0);
      end
      chk("s5_saturated", 32'(bus.lock_loss_cnt), 32'd255);

      // rst mid-RELEASE at E16 with locked still high.
      for (int e = 1; e <= 30; e++) begin
         tick((e == 16), 1'b1);
         if (e == 15) begin
            chk("s6_e15_rst_out", 32'(bus.rst_out),       32'hC);
            chk("s6_e15_loss",    32'(bus.lock_loss_cnt), 32'd255);
         end
         if (e == 16) begin
            chk("s6_e16_rst_out", 32'(bus.rst_out),       32'hF);
            chk("s6_e16_done",    32'(bus.seq_done),      32'd0);
            chk("s6_e16_loss",    32'(bus.lock_loss_cnt), 32'd0);
            chk("s6_e16_state",   32'(bus.state_o),       32'd0);
         end
         if (e == 25) chk("s6_e25_rst_out", 32'(bus.rst_out), 32'hF);
         if (e == 26) chk("s6_e26_rst_out", 32'(bus.rst_out), 32'hE);
      end

      // Randomized lock/unlock bursts with occasional resets.
      for (int b = 0; b < 150; b++) begin
         hi = $urandom_range(1, 40);
         lo = $urandom_range(1, 6);
         if ($urandom_range(0, 9) == 0) tick(1'b1, 1'($urandom_range(0, 1)));
         for (int c = 0; c < hi; c++) tick(1'b0, 1'b1);
         for (int c = 0; c < lo; c++) tick(1'b0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pll_rst_seq.md
Name: pll_rst_seq

Overview:
- Reset sequencer directly downstream of the clock wizard (ip_clk_wiz).
- Synchronizes the wizard's asynchronous `locked` flag and waits for it to stay stable.
- Then releases per-domain resets in a fixed order: 100 MHz, 100 MHz phase-shifted, 50 MHz, 25 MHz logic.
- On any lock loss, re-asserts all resets and counts the event for debug.

Parameters:
- SYNC_STAGES, 2: flops in the `locked` synchronizer chain; legal range 2..4.
- LOCK_STABLE_CYCLES, 64: consecutive cycles `locked_s` must be high before the first release; minimum 1.
- STAGE_GAP, 16: cycles between successive stage releases; minimum 1.
- NUM_STAGES, 4: number of sequenced reset outputs; legal range 1..8.

Ports:
- clk  input  1  system reference clock, same net that feeds the clock wizard.
- rst  input  1  synchronous, active-high block reset.
- locked  input  1  clock wizard lock flag; asynchronous to clk.
- rst_out  output  NUM_STAGES  active-high reset per domain; bit 0 is released first.
- seq_done  output  1  high while every rst_out bit is released.
- lock_loss_cnt  output  8  saturating count of lock-loss events.
- state_o  output  2  FSM state for debug: WAIT_LOCK=0, STABLE=1, RELEASE=2, RUN=3.

Behaviour:
- Clocking and reset:
  - Single clock `clk`; reset `rst` is synchronous and active-high.
  - At any edge with rst=1: rst_out=all ones, seq_done=0, lock_loss_cnt=0, state=WAIT_LOCK, synchronizer chain cleared to 0, counters cleared.
  - rst overrides every other event in the same cycle.
- Synchronizer:
  - `locked` passes through SYNC_STAGES flops; the output is `locked_s`.
  - If `locked` is first sampled high at edge E1, `locked_s` is high after edge Es = E1+SYNC_STAGES-1.
- Counter:
  - One cycle counter, width clog2(max(LOCK_STABLE_CYCLES, STAGE_GAP))+1.
  - Stage index width is clog2(NUM_STAGES)+1.
- WAIT_LOCK:
  - rst_out all ones, seq_done=0, counter=0.
  - locked_s=1 at an edge: go to STABLE, counter=1.
- STABLE:
  - Counter increments each edge while locked_s=1.
  - When the counter reaches LOCK_STABLE_CYCLES, at that edge: rst_out[0]<=0, stage index=1, counter=0, go to RELEASE.
  - If NUM_STAGES=1: also seq_done<=1 and go directly to RUN.
  - Net timing: rst_out[0] falls at edge Es+LOCK_STABLE_CYCLES.
- RELEASE:
  - Counter increments every edge.
  - When the counter reaches STAGE_GAP: rst_out[stage]<=0, stage+1, counter=0.
  - Net timing: rst_out[k] falls at edge Es+LOCK_STABLE_CYCLES+k*STAGE_GAP.
  - Release of the last stage: seq_done<=1 at the same edge; go to RUN.
- RUN:
  - Holds all rst_out=0 and seq_done=1 indefinitely while locked_s=1.
- Lock loss (locked_s=0 sampled in STABLE, RELEASE or RUN):
  - At that edge: rst_out<=all ones, seq_done<=0, counter=0, stage=0, go to WAIT_LOCK.
  - lock_loss_cnt increments, saturating at 255.
  - Lock loss takes priority over a release scheduled for the same edge; that release does not happen.
- Glitches: a single-cycle low on `locked_s` in STABLE restarts the full LOCK_STABLE_CYCLES wait.
- Release order invariant: rst_out bits only deassert in index order.
  - rst_out[k] low implies rst_out[j] low for all j<k.
- Re-lock after loss: the full sequence restarts from stage 0.
- Outputs: all are registered; no combinational path from `locked` to any output.

Test Plan:
(Params SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, STAGE_GAP=4, NUM_STAGES=4; E1 is the first edge sampling locked=1, so Es=E2.)
1. Power-up: rst=1 for 10 cycles, locked=0 → rst_out=4'b1111, seq_done=0, lock_loss_cnt=0, state_o=0 throughout.
2. Clean lock: release rst, raise locked before E1 → rst_out[0] falls at E10, [1] at E14, [2] at E18, [3] at E22. seq_done rises at E22; state_o=3 after E22.
3. Glitch during STABLE: locked low for one cycle, sampled at E5 → state_o=0 two edges later, no release at E10. Release restarts counting from the new Es. lock_loss_cnt=1.
4. Loss during RELEASE: drop locked so locked_s=0 is sampled at E14 → rst_out[1] never falls; rst_out=4'b1111 after E14; lock_loss_cnt=1. Re-raising locked reproduces scenario 2 timing relative to the new Es.
5. Loss in RUN repeated 300 times → each loss re-asserts all resets within SYNC_STAGES+1 cycles; lock_loss_cnt saturates at 255.
6. rst asserted mid-RELEASE (at E16, locked still high) → at E16 all outputs return to reset values and lock_loss_cnt=0. After rst drops, the sequence restarts with the synchronizer refilled from 0.
